// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 7-segment display: recovers the BCD digits being shown
// by waiting for each digit to dwell stably, then publishes the full value as one frame.
module seg7_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    multi_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    localparam logic ST_SCAN    = 1'b0;
    localparam logic ST_PUBLISH = 1'b1;

    logic [6:0]              s_seg, p_seg;
    logic [NUM_DIGITS-1:0]   s_an, p_an;
    logic [CW-1:0]           cnt, cnt_next;
    logic [NUM_DIGITS-1:0]   mask, mask_next, cap_bit;
    logic [4*NUM_DIGITS-1:0] shadow_code;
    logic [NUM_DIGITS-1:0]   shadow_err;
    logic                    state, state_next;

    logic [3:0]              code;
    logic                    illegal;
    logic [NUM_DIGITS-1:0]   low;
    logic                    sel_valid, sel_blank, same, capture;
    logic [IW-1:0]           sel_idx;

    always_comb begin
        illegal = 1'b0;
        case (s_seg)
            7'b0000001: code = 4'h0;
            7'b1001111: code = 4'h1;
            7'b0010010: code = 4'h2;
            7'b0000110: code = 4'h3;
            7'b1001100: code = 4'h4;
            7'b0100100: code = 4'h5;
            7'b0100000: code = 4'h6;
            7'b0001111: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0001100: code = 4'h9;
            7'b1111111: code = 4'hF;
            default: begin
                code    = 4'hE;
                illegal = 1'b1;
            end
        endcase
    end

    // A select is usable only when exactly one enable is low; more than one is a fault.
    always_comb begin
        low       = ~s_an;
        sel_blank = (low == '0);
        sel_valid = !sel_blank && ((low & (low - 1'b1)) == '0);
        sel_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (low[i]) sel_idx = IW'(i);
        end
    end

    always_comb begin
        same = (s_seg == p_seg) && (s_an == p_an);
        if (!sel_valid)
            cnt_next = '0;
        else if (!same)
            cnt_next = CW'(1);
        else if (cnt == CNT_MAX)
            cnt_next = cnt;
        else
            cnt_next = cnt + 1'b1;
        capture = sel_valid && (cnt_next == CNT_MAX) && (cnt != CNT_MAX);
        cap_bit = capture ? (NUM_DIGITS'(1) << sel_idx) : '0;
    end

    // The publish cycle clears the mask, but a capture landing there starts the next frame.
    always_comb begin
        mask_next  = ((state == ST_PUBLISH) ? '0 : mask) | cap_bit;
        state_next = ST_SCAN;
        if (state == ST_SCAN && (&mask_next))
            state_next = ST_PUBLISH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg       <= '1;
            s_an        <= '1;
            p_seg       <= '1;
            p_an        <= '1;
            cnt         <= '0;
            mask        <= '0;
            shadow_code <= '1;
            shadow_err  <= '0;
            state       <= ST_SCAN;
            digits_out  <= '1;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            s_seg       <= seg_n;
            s_an        <= an_n;
            p_seg       <= s_seg;
            p_an        <= s_an;
            cnt         <= cnt_next;
            mask        <= mask_next;
            state       <= state_next;
            multi_err   <= !sel_valid && !sel_blank;
            frame_valid <= (state == ST_PUBLISH);
            if (capture) begin
                shadow_code[sel_idx*4 +: 4] <= code;
                shadow_err[sel_idx]         <= illegal;
            end
            if (state == ST_PUBLISH) begin
                digits_out <= shadow_code;
                digit_err  <= shadow_err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: table of whole-frame vectors plus
// hand-written sequences for reset, short dwell, multi-enable, overwrite and back-to-back.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'b1111111;
    logic [3:0]  an_n = 4'b1111;
    logic [15:0] digits_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        multi_err;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int multis = 0;
    int cycle = 0;
    logic [15:0] lastDigits = 16'h0;
    logic [3:0]  lastErr = 4'h0;
    int          frameCycles[$];
    logic [15:0] frameDigits[$];

    typedef struct {
        string       name;
        logic [27:0] segs;
        logic [15:0] expDigits;
        logic [3:0]  expErr;
    } vec_t;

    vec_t vecs[4];

    seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_n(seg_n),
        .an_n(an_n),
        .digits_out(digits_out),
        .digit_err(digit_err),
        .frame_valid(frame_valid),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_valid) begin
            frames++;
            lastDigits = digits_out;
            lastErr    = digit_err;
            frameCycles.push_back(cycle);
            frameDigits.push_back(digits_out);
        end
        if (multi_err) multis++;
        cycle++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [6:0] segOf(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic showDigit(input int d, input logic [6:0] seg, input int n);
        applyStimulus(~(4'b0001 << d), seg, n);
    endtask

    task automatic blank(input int n);
        applyStimulus(4'b1111, 7'b1111111, n);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_digits"}, 32'(digits_out), 32'hFFFF);
        checkOutput({tag, "_err"}, 32'(digit_err), 32'h0);
        checkOutput({tag, "_fv"}, 32'(frame_valid), 32'h0);
        checkOutput({tag, "_multi"}, 32'(multi_err), 32'h0);
    endtask

    initial begin
        int f0;
        int m0;
        int q0;

        vecs[0] = '{"count1234", {segOf(4'h1), segOf(4'h2), segOf(4'h3), segOf(4'h4)}, 16'h1234, 4'b0000};
        vecs[1] = '{"illegalBlank", {segOf(4'h0), segOf(4'h0), 7'b1111110, 7'b1111111}, 16'h00EF, 4'b0010};
        vecs[2] = '{"count5678", {segOf(4'h5), segOf(4'h6), segOf(4'h7), segOf(4'h8)}, 16'h5678, 4'b0000};
        vecs[3] = '{"nineErr", {segOf(4'h9), 7'b0110000, segOf(4'h0), segOf(4'h8)}, 16'h9E08, 4'b0100};

        repeat (3) @(negedge clk);
        checkResetValues("initReset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            f0 = frames;
            for (int d = 3; d >= 0; d--) showDigit(d, vecs[v].segs[7*d +: 7], 6);
            blank(3);
            checkOutput({vecs[v].name, "_frames"}, 32'(frames - f0), 32'd1);
            checkOutput({vecs[v].name, "_digits"}, 32'(lastDigits), 32'(vecs[v].expDigits));
            checkOutput({vecs[v].name, "_err"}, 32'(lastErr), 32'(vecs[v].expErr));
        end

        // Reset in the middle of a scan, then a partial frame must not publish
        showDigit(3, segOf(4'h4), 6);
        showDigit(2, segOf(4'h3), 6);
        an_n  = 4'b1101;
        seg_n = segOf(4'h2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        f0 = frames;
        showDigit(1, segOf(4'h2), 6);
        showDigit(0, segOf(4'h1), 6);
        blank(3);
        checkOutput("partialAfterReset_frames", 32'(frames - f0), 32'd0);
        checkOutput("partialAfterReset_digits", 32'(digits_out), 32'hFFFF);

        // Short dwell on digit 2, then a full dwell
        f0 = frames;
        showDigit(3, segOf(4'h4), 6);
        showDigit(1, segOf(4'h2), 6);
        showDigit(0, segOf(4'h1), 6);
        showDigit(2, segOf(4'h3), 3);
        blank(4);
        checkOutput("shortDwell_frames", 32'(frames - f0), 32'd0);
        showDigit(2, segOf(4'h3), 4);
        blank(3);
        checkOutput("fullDwell_frames", 32'(frames - f0), 32'd1);
        checkOutput("fullDwell_digits", 32'(lastDigits), 32'h4321);

        // Multi-enable: three pulses, counter restarts on the next valid select
        f0 = frames;
        m0 = multis;
        showDigit(3, segOf(4'h7), 6);
        showDigit(2, segOf(4'h8), 6);
        showDigit(1, segOf(4'h9), 6);
        blank(2);
        applyStimulus(4'b1100, segOf(4'h0), 3);
        showDigit(0, segOf(4'h0), 3);
        blank(3);
        checkOutput("multi_pulses", 32'(multis - m0), 32'd3);
        checkOutput("multi_noFrame", 32'(frames - f0), 32'd0);
        showDigit(0, segOf(4'h0), 4);
        blank(3);
        checkOutput("multiAfter_frames", 32'(frames - f0), 32'd1);
        checkOutput("multiAfter_digits", 32'(lastDigits), 32'h7890);

        // Overwrite of an already captured digit before the frame completes
        f0 = frames;
        showDigit(0, segOf(4'h5), 6);
        showDigit(1, segOf(4'h3), 6);
        showDigit(2, segOf(4'h2), 6);
        showDigit(0, segOf(4'h7), 6);
        showDigit(3, segOf(4'h1), 6);
        blank(3);
        checkOutput("overwrite_frames", 32'(frames - f0), 32'd1);
        checkOutput("overwrite_digits", 32'(lastDigits), 32'h1237);
        checkOutput("overwrite_err", 32'(lastErr), 32'h0);

        // Back-to-back frames with a 5-cycle dwell
        f0 = frames;
        q0 = frameCycles.size();
        for (int f = 0; f < 3; f++) begin
            for (int d = 3; d >= 0; d--) showDigit(d, segOf(4'((f * 4 + 4 - d) % 10)), 5);
        end
        blank(3);
        checkOutput("b2b_frames", 32'(frames - f0), 32'd3);
        if (frameCycles.size() >= q0 + 3) begin
            checkOutput("b2b_value0", 32'(frameDigits[q0]), 32'h1234);
            checkOutput("b2b_value1", 32'(frameDigits[q0 + 1]), 32'h5678);
            checkOutput("b2b_value2", 32'(frameDigits[q0 + 2]), 32'h9012);
            checkOutput("b2b_period01", 32'(frameCycles[q0 + 1] - frameCycles[q0]), 32'd20);
            checkOutput("b2b_period12", 32'(frameCycles[q0 + 2] - frameCycles[q0 + 1]), 32'd20);
        end
        checkOutput("idle_fv", 32'(frame_valid), 32'h0);
        checkOutput("idle_hold", 32'(digits_out), 32'h9012);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
